// File: rtl/mem_stage.sv
// Memory-access stage: aligns loads/stores onto a req/ack data port and
// registers the writeback bundle for the WB stage.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic            mem_rd_i,
  input  logic            mem_wr_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      wb_sel_i,
  input  logic [4:0]      rd_i,
  input  logic            wb_en_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_ack_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  output logic            stall_o,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_en_o,
  output logic            misaligned_o
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state_q, state_d;

  logic            mem_op;
  logic            is_st;
  logic            is_byte;
  logic            is_half;
  logic            misal;
  logic [1:0]      lo;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n;

  logic [2:0]      f3_q;
  logic [1:0]      lo_q;
  logic [1:0]      sel_q;
  logic [4:0]      rd_q;
  logic            en_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] pc4_q;

  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] acc_data;
  logic [XLEN-1:0] alu_data;

  assign lo     = alu_result_i[1:0];
  assign mem_op = valid_i & (mem_rd_i | mem_wr_i);
  assign is_st  = mem_wr_i;

  always_comb begin
    is_byte = (funct3_i == 3'b000) || (funct3_i == 3'b100);
    is_half = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    misal   = 1'b0;
    unique case (1'b1)
      is_byte: misal = 1'b0;
      is_half: misal = lo[0];
      default: misal = (lo != 2'b00);
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && !misal) begin
          state_d = ACCESS;
          stall_o = 1'b1;
        end
      end
      ACCESS: begin
        stall_o = ~dmem_ack_i;
        if (dmem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stores replicate the datum across lanes; loads always fetch the word.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = rs2_data_i;
    if (is_st) begin
      unique case (1'b1)
        is_byte: begin
          be_n    = 4'b0001 << lo;
          wdata_n = {(XLEN/8){rs2_data_i[7:0]}};
        end
        is_half: begin
          be_n    = 4'b0011 << lo;
          wdata_n = {(XLEN/16){rs2_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_v = dmem_rdata_i[{lo_q, 3'b000} +: 8];
    half_v = dmem_rdata_i[{lo_q[1], 4'b0000} +: 16];
    ld_val = dmem_rdata_i;
    unique case (f3_q)
      3'b000:  ld_val = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, byte_v};
      3'b001:  ld_val = {{(XLEN-16){half_v[15]}}, half_v};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, half_v};
      default: ld_val = dmem_rdata_i;
    endcase
  end

  always_comb begin
    acc_data = alu_q;
    unique case (sel_q)
      2'b01:   acc_data = ld_val;
      2'b10:   acc_data = pc4_q;
      default: acc_data = alu_q;
    endcase
    alu_data = (wb_sel_i == 2'b10) ? pc_plus4_i : alu_result_i;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= '0;
      wb_rd_o      <= '0;
      wb_en_o      <= 1'b0;
      misaligned_o <= 1'b0;
      f3_q         <= '0;
      lo_q         <= '0;
      sel_q        <= '0;
      rd_q         <= '0;
      en_q         <= 1'b0;
      alu_q        <= '0;
      pc4_q        <= '0;
    end else begin
      wb_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_op && !misal) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= is_st;
            dmem_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
            dmem_wdata_o <= wdata_n;
            dmem_be_o    <= be_n;
            f3_q         <= funct3_i;
            lo_q         <= lo;
            sel_q        <= wb_sel_i;
            rd_q         <= rd_i;
            en_q         <= wb_en_i;
            alu_q        <= alu_result_i;
            pc4_q        <= pc_plus4_i;
          end else if (mem_op) begin
            wb_valid_o   <= 1'b1;
            wb_data_o    <= '0;
            wb_rd_o      <= rd_i;
            wb_en_o      <= 1'b0;
            misaligned_o <= 1'b1;
          end else if (valid_i) begin
            wb_valid_o <= 1'b1;
            wb_data_o  <= alu_data;
            wb_rd_o    <= rd_i;
            wb_en_o    <= wb_en_i;
          end
        end
        ACCESS: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            wb_valid_o <= 1'b1;
            wb_data_o  <= acc_data;
            wb_rd_o    <= rd_q;
            wb_en_o    <= en_q & ~dmem_we_o;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage against a spec-level model of lanes,
// extension, alignment and handshake timing.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] rs2_data_i;
  logic [31:0] pc_plus4_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  funct3_i;
  logic [1:0]  wb_sel_i;
  logic [4:0]  rd_i;
  logic        wb_en_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        stall_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_en_o;
  logic        misaligned_o;

  int n_chk  = 0;
  int n_pass = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .alu_result_i (alu_result_i),
    .rs2_data_i   (rs2_data_i),
    .pc_plus4_i   (pc_plus4_i),
    .mem_rd_i     (mem_rd_i),
    .mem_wr_i     (mem_wr_i),
    .funct3_i     (funct3_i),
    .wb_sel_i     (wb_sel_i),
    .rd_i         (rd_i),
    .wb_en_i      (wb_en_i),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_be_o    (dmem_be_o),
    .stall_o      (stall_o),
    .wb_valid_o   (wb_valid_o),
    .wb_data_o    (wb_data_o),
    .wb_rd_o      (wb_rd_o),
    .wb_en_o      (wb_en_o),
    .misaligned_o (misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic int fsize(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] d);
    int unsigned k;
    logic [31:0] v;
    k = a % 4;
    if (fsize(f3) == 1) begin
      v = (d >> (8 * k)) % 256;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (fsize(f3) == 2) begin
      v = (d >> (16 * (k / 2))) % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic scramble();
    valid_i      = 1'($urandom);
    mem_rd_i     = 1'($urandom);
    mem_wr_i     = 1'($urandom);
    alu_result_i = $urandom;
    rs2_data_i   = $urandom;
    pc_plus4_i   = $urandom;
    funct3_i     = 3'($urandom);
    wb_sel_i     = 2'($urandom);
    rd_i         = 5'($urandom);
    wb_en_i      = 1'($urandom);
  endtask

  // Entered and left at a negedge with the stage idle.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] pc4, input logic ld,
                        input logic st, input logic [2:0] f3,
                        input logic [1:0] sel, input logic [4:0] rd,
                        input logic en, input logic [31:0] rdata,
                        input int dly);
    logic        mem;
    logic        mis;
    int          sz;
    int unsigned k;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wexp;
    mem = ld | st;
    sz  = fsize(f3);
    k   = alu % 4;
    mis = mem && ((alu % sz) != 0);
    be  = 4'hF;
    wd  = rs2;
    if (st && sz == 1) begin
      be = 4'(1 << k);
      wd = (rs2 % 256) * 32'h0101_0101;
    end else if (st && sz == 2) begin
      be = 4'(3 << k);
      wd = (rs2 % 65536) * 32'h0001_0001;
    end
    valid_i      = 1'b1;
    alu_result_i = alu;
    rs2_data_i   = rs2;
    pc_plus4_i   = pc4;
    mem_rd_i     = ld;
    mem_wr_i     = st;
    funct3_i     = f3;
    wb_sel_i     = sel;
    rd_i         = rd;
    wb_en_i      = en;
    dmem_ack_i   = 1'($urandom);
    dmem_rdata_i = $urandom;
    #1;
    chk("stall_accept", stall_o, mem && !mis);
    @(negedge clk);
    dmem_ack_i = 1'b0;
    if (!mem || mis) begin
      valid_i = 1'b0;
      chk("wb_valid", wb_valid_o, 1'b1);
      chk("misaligned", misaligned_o, mis);
      chk("no_req", dmem_req_o, 1'b0);
      chk("wb_rd", wb_rd_o, rd);
      chk("wb_en", wb_en_o, mis ? 1'b0 : en);
      if (!mis) chk("wb_data_alu", wb_data_o, (sel == 2'b10) ? pc4 : alu);
      @(negedge clk);
      chk("wb_valid_pulse", wb_valid_o, 1'b0);
      chk("mis_pulse", misaligned_o, 1'b0);
    end else begin
      chk("req", dmem_req_o, 1'b1);
      chk("we", dmem_we_o, st);
      chk("addr", dmem_addr_o, alu - k);
      chk("be", dmem_be_o, be);
      if (st) chk("wdata", dmem_wdata_o, wd);
      chk("wb_idle", wb_valid_o, 1'b0);
      scramble();
      for (int i = 0; i < dly; i++) begin
        #1;
        chk("stall_wait", stall_o, 1'b1);
        @(negedge clk);
        chk("req_hold", dmem_req_o, 1'b1);
        chk("addr_hold", dmem_addr_o, alu - k);
        chk("wb_wait", wb_valid_o, 1'b0);
      end
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = rdata;
      #1;
      chk("stall_ack", stall_o, 1'b0);
      @(negedge clk);
      dmem_ack_i = 1'b0;
      valid_i    = 1'b0;
      chk("req_drop", dmem_req_o, 1'b0);
      chk("wb_valid", wb_valid_o, 1'b1);
      chk("wb_rd", wb_rd_o, rd);
      chk("wb_en", wb_en_o, st ? 1'b0 : en);
      chk("misaligned", misaligned_o, 1'b0);
      if (!st) begin
        wexp = (sel == 2'b01) ? exp_load(f3, alu, rdata)
             : (sel == 2'b10) ? pc4 : alu;
        chk("wb_data_mem", wb_data_o, wexp);
      end
      @(negedge clk);
      chk("wb_valid_pulse", wb_valid_o, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic        ld;
    logic        st;
    logic [1:0]  sel;
    int          kind;
    rst          = 1'b1;
    valid_i      = 1'b0;
    alu_result_i = '0;
    rs2_data_i   = '0;
    pc_plus4_i   = '0;
    mem_rd_i     = 1'b0;
    mem_wr_i     = 1'b0;
    funct3_i     = '0;
    wb_sel_i     = '0;
    rd_i         = '0;
    wb_en_i      = 1'b0;
    dmem_rdata_i = '0;
    dmem_ack_i   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_be", dmem_be_o, 4'h0);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_wb_data", wb_data_o, 32'h0);
    chk("rst_mis", misaligned_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h0000_1234, 32'h0, 32'h44, 0, 0, 3'b000, 2'b00,
           5'd5, 1, 32'h0, 0);
    run_op(32'h0000_0103, 32'h0, 32'h48, 1, 0, 3'b000, 2'b01,
           5'd6, 1, 32'h80FF_0000, 2);
    run_op(32'h0000_0102, 32'h0, 32'h4C, 1, 0, 3'b101, 2'b01,
           5'd7, 1, 32'hBEEF_1234, 0);
    run_op(32'h0000_0201, 32'h0000_00A5, 32'h50, 0, 1, 3'b000, 2'b00,
           5'd8, 1, 32'h0, 1);
    run_op(32'h0000_0302, 32'h0, 32'h54, 1, 0, 3'b010, 2'b01,
           5'd9, 1, 32'h0, 0);

    // Reset while a request is outstanding, then a stale ack.
    valid_i      = 1'b1;
    mem_rd_i     = 1'b1;
    mem_wr_i     = 1'b0;
    funct3_i     = 3'b010;
    alu_result_i = 32'h400;
    @(negedge clk);
    valid_i = 1'b0;
    chk("rst_mid_req", dmem_req_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_drop", dmem_req_o, 1'b0);
    chk("rst_mid_addr", dmem_addr_o, 32'h0);
    chk("rst_mid_wb", wb_valid_o, 1'b0);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("rst_mid_stall", stall_o, 1'b0);
    @(negedge clk);
    dmem_ack_i = 1'b0;
    chk("stale_ack_wb", wb_valid_o, 1'b0);
    chk("stale_ack_req", dmem_req_o, 1'b0);
    chk("stale_ack_data", wb_data_o, 32'h0);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom % 4;
      ld   = (kind == 1) || (kind == 3);
      st   = (kind == 2) || (kind == 3);
      a    = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      if (st) f3 = 3'($urandom % 3);
      else    f3 = 3'($urandom);
      sel = 2'($urandom);
      if (!ld && !st && sel == 2'b01) sel = 2'b00;
      run_op(a, $urandom, $urandom, ld, st, f3, sel, 5'($urandom),
             1'($urandom), $urandom, $urandom % 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (effective address or ALU value), the store data and the PC+4 link value.
- Performs loads and stores over a simple req/ack data-memory port, with byte-lane alignment and load sign/zero extension.
- Presents a registered writeback bundle to the WB stage and stalls upstream while an access is outstanding.

Parameters:
- XLEN, 32, datapath and address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- valid_i  input  1  an instruction is presented this cycle.
- alu_result_i  input  XLEN  ALU result or effective address.
- rs2_data_i  input  XLEN  store data.
- pc_plus4_i  input  XLEN  link value for JAL/JALR.
- mem_rd_i  input  1  load instruction.
- mem_wr_i  input  1  store instruction.
- funct3_i  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- wb_sel_i  input  2  writeback source: 00 ALU, 01 memory, 10 pc+4, 11 reserved (behaves as 00).
- rd_i  input  5  destination register.
- wb_en_i  input  1  register write enable.
- dmem_rdata_i  input  XLEN  read data, valid with ack.
- dmem_ack_i  input  1  access complete.
- dmem_req_o  output  1  access request.
- dmem_we_o  output  1  write request.
- dmem_addr_o  output  XLEN  word-aligned address (bits [1:0] = 0).
- dmem_wdata_o  output  XLEN  lane-replicated store data.
- dmem_be_o  output  4  byte enables.
- stall_o  output  1  upstream must hold its outputs (combinational).
- wb_valid_o  output  1  writeback bundle valid.
- wb_data_o  output  XLEN  writeback value.
- wb_rd_o  output  5  destination register.
- wb_en_o  output  1  register write enable to WB.
- misaligned_o  output  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset: state IDLE; all registered outputs are 0 (dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, wb_*, misaligned_o).
- FSM states:
  - IDLE: accepts an instruction when valid_i = 1.
  - ACCESS: request outstanding.
- Memory op = valid_i & (mem_rd_i | mem_wr_i). If both mem_rd_i and mem_wr_i are set, the op is treated as a store.
- Alignment:
  - H/HU is misaligned if addr[0] = 1.
  - W is misaligned if addr[1:0] != 0.
  - B is always aligned.
- IDLE, non-memory instruction:
  - Registers the wb bundle at the next edge: wb_valid_o = 1; wb_data_o = ALU or pc+4 per wb_sel_i; rd and wb_en pass through.
  - Latency 1; no stall.
- IDLE, aligned memory op:
  - Latch addr, funct3, rd, wb_en, wb_sel and store data.
  - Drive dmem_req_o = 1 from the next edge; go to ACCESS.
  - stall_o = 1 in the accept cycle.
  - wb_valid_o = 0 the following cycle.
- IDLE, misaligned memory op:
  - No request issued.
  - Next cycle: wb_valid_o = 1, wb_en_o = 0, misaligned_o = 1 for one cycle.
  - No stall.
- ACCESS:
  - dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o and dmem_be_o are held stable until ack.
  - stall_o = ~dmem_ack_i. Upstream advances in the ack cycle; valid_i is ignored while in ACCESS.
  - On ack: drop req at the next edge; return to IDLE.
  - Load: wb_data_o = extended read data (or pc+4/ALU per the latched wb_sel). Store: wb_en_o = 0.
  - wb_valid_o = 1 for one cycle.
- Minimum memory-op latency: accept at cycle T, req visible at T+1, ack at T+1 earliest, wb_valid_o at T+2. Ack may stall indefinitely.
- dmem_ack_i outside ACCESS is ignored.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 << addr[1:0]; wdata = half replicated x2.
  - SW: be = 1111.
- Loads:
  - be = 1111.
  - Select byte at addr[1:0] or half at addr[1].
  - B/H sign-extend; BU/HU zero-extend.
  - Undefined funct3 codes load as W.
- wb_valid_o and misaligned_o are single-cycle pulses; each is 0 in any cycle with no completion.
- Reset mid-ACCESS: back to IDLE at that edge; req deasserts; no writeback is produced; a later stale ack is ignored.

Test Plan:
- ALU op: valid_i = 1, wb_sel = 00, alu = 0x0000_1234, rd = 5, wb_en = 1 → next cycle wb_valid_o = 1, wb_data_o = 0x0000_1234, wb_rd_o = 5, stall_o never high.
- LB, sign extension: addr 0x103, ack with rdata 0x80FF_0000 two cycles after req → dmem_addr_o = 0x100, be = 1111, stall_o high until the ack cycle, wb_data_o = 0xFFFF_FF80, one wb_valid_o pulse.
- LHU: addr 0x102, rdata 0xBEEF_1234, immediate ack → wb_data_o = 0x0000_BEEF, wb_valid_o at T+2.
- SB: addr 0x201, rs2 = 0x0000_00A5 → dmem_we_o = 1, addr 0x200, be = 0010, wdata = 0xA5A5_A5A5, then wb_en_o = 0.
- Misaligned LW: addr 0x302 → no dmem_req_o; misaligned_o = 1 one cycle; wb_en_o = 0.
- rst asserted in ACCESS before ack, ack then arrives in IDLE → dmem_req_o = 0 after the edge, no wb_valid_o, all outputs zero.
